// File: rtl/dmem_bridge.sv
// Data-side bridge from the CPU31 data port to the DMEM word array: range/alignment
// screening, request/ready sequencing and sticky fault status.
//
// state  | meaning
// IDLE   | waiting for cpu_req_i
// ACCESS | one DMEM read or write strobe cycle
// RESP   | cpu_ready_o pulse, load data on cpu_rdata_o
// FAULT  | cpu_ready_o pulse for a rejected access, no DMEM strobe
module dmem_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          DEPTH_LOG2 = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_ready_o,
    output logic                  dm_ena_o,
    output logic                  dm_w_o,
    output logic                  dm_r_o,
    output logic [DEPTH_LOG2-1:0] dm_addr_o,
    output logic [31:0]           dm_wdata_o,
    input  logic [31:0]           dm_rdata_i,
    output logic                  fault_o,
    output logic [31:0]           fault_addr_o,
    output logic [7:0]            fault_cnt_o,
    input  logic                  fault_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   dm_addr_q, dm_addr_d;
    logic [31:0]             dm_wdata_q, dm_wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    fault_q, fault_d;
    logic [31:0]             fault_addr_q, fault_addr_d;
    logic [7:0]              fault_cnt_q, fault_cnt_d;

    logic [31-DEPTH_LOG2-2:0] offset_hi;
    logic [DEPTH_LOG2-1:0]    word_idx;
    logic [1:0]               offset_lo;
    logic [1:0]               addr_lo;
    logic                     in_range;
    logic                     aligned;

    // Addresses below the base wrap to large offsets and fail the range test.
    assign {offset_hi, word_idx, offset_lo} = cpu_addr_i - BASE_ADDR;
    // Recover cpu_addr_i[1:0] from the offset so every difference bit is consumed.
    assign addr_lo  = offset_lo + BASE_ADDR[1:0];
    assign in_range = (offset_hi == '0);
    assign aligned  = (addr_lo == 2'b00);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        rdata_d      = '0;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_cnt_d  = fault_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    addr_d = cpu_addr_i;
                    we_d   = cpu_we_i;
                    if (in_range && aligned) begin
                        state_d    = S_ACCESS;
                        dm_addr_d  = word_idx;
                        dm_wdata_d = cpu_wdata_i;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                rdata_d = we_q ? '0 : dm_rdata_i;
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fault_clr_i) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
            fault_cnt_d  = '0;
        end

        // A fault on the same edge as a clear is recorded as the first one after it.
        if (state_q == S_FAULT) begin
            fault_d = 1'b1;
            if (fault_clr_i) begin
                fault_cnt_d  = 8'd1;
                fault_addr_d = addr_q;
            end else begin
                if (fault_cnt_q != 8'hFF) begin
                    fault_cnt_d = fault_cnt_q + 8'd1;
                end
                if (!fault_q) begin
                    fault_addr_d = addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    // Strobes decode straight from the state register so reset removes them at once.
    assign dm_ena_o     = (state_q == S_ACCESS);
    assign dm_w_o       = (state_q == S_ACCESS) && we_q;
    assign dm_r_o       = (state_q == S_ACCESS) && !we_q;
    assign dm_addr_o    = dm_addr_q;
    assign dm_wdata_o   = dm_wdata_q;
    assign cpu_ready_o  = (state_q == S_RESP) || (state_q == S_FAULT);
    assign cpu_rdata_o  = rdata_q;
    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;
    assign fault_cnt_o  = fault_cnt_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: DMEM array model, table vectors, randomized accesses
// against an address-arithmetic reference model, and multi-cycle corner sequences.
module tb_dmem_bridge;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, dm_ena, dm_w, dm_r;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        fault;
    logic [31:0] fault_addr;
    logic [7:0]  fault_cnt;
    logic        fault_clr;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem     [2048];
    logic [31:0] ref_mem [2048];
    bit          m_fault;
    logic [31:0] m_faddr;
    int          m_fcnt;

    always #5 clk = ~clk;

    dmem_bridge #(.BASE_ADDR(32'h1001_0000), .DEPTH_LOG2(11)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
        .dm_ena_o(dm_ena), .dm_w_o(dm_w), .dm_r_o(dm_r), .dm_addr_o(dm_addr),
        .dm_wdata_o(dm_wdata), .dm_rdata_i(dm_rdata),
        .fault_o(fault), .fault_addr_o(fault_addr), .fault_cnt_o(fault_cnt),
        .fault_clr_i(fault_clr)
    );

    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_ena && dm_w) mem[dm_addr] <= dm_wdata;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          ok;
        logic [10:0] idx;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_fault_regs();
        check("fault", {31'b0, fault}, {31'b0, m_fault});
        check("fault_addr", fault_addr, m_faddr);
        check("fault_cnt", {24'b0, fault_cnt}, m_fcnt);
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit exp_ok, input logic [10:0] exp_idx, input bit clr_on_exit);
        int lat, nw, nr, ne;
        logic [31:0] rd, seen_wd, exp_rd;
        logic [10:0] seen_idx;
        lat = 0; nw = 0; nr = 0; ne = 0;
        rd = '0; seen_wd = '0; seen_idx = '0;
        exp_rd = (exp_ok && !we) ? ref_mem[exp_idx] : 32'h0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cpu_req = 1'b0;
                cpu_we = ($urandom_range(0, 1) != 0);
                cpu_addr = $urandom;
                cpu_wdata = $urandom;
            end
            if (dm_ena) ne++;
            if (dm_w) begin nw++; seen_idx = dm_addr; seen_wd = dm_wdata; end
            if (dm_r) begin nr++; seen_idx = dm_addr; end
            if (cpu_ready) begin
                lat = k;
                rd = cpu_rdata;
                if (clr_on_exit) fault_clr = 1'b1;
                break;
            end
        end
        check("latency", lat, exp_ok ? 2 : 1);
        check("cpu_rdata", rd, exp_rd);
        check("dm_ena cycles", ne, exp_ok ? 1 : 0);
        check("dm_w cycles", nw, (exp_ok && we) ? 1 : 0);
        check("dm_r cycles", nr, (exp_ok && !we) ? 1 : 0);
        if (exp_ok) check("dm_addr", {21'b0, seen_idx}, {21'b0, exp_idx});
        if (exp_ok && we) check("dm_wdata", seen_wd, wdata);

        if (exp_ok && we) ref_mem[exp_idx] = wdata;
        if (clr_on_exit) begin m_fault = 0; m_faddr = '0; m_fcnt = 0; end
        if (!exp_ok) begin
            if (!m_fault) m_faddr = addr;
            m_fault = 1;
            if (m_fcnt < 255) m_fcnt++;
        end
        @(negedge clk);
        fault_clr = 1'b0;
        check_fault_regs();
    endtask

    // Reference decode: word offset from base, valid if below 2^11 words and word aligned.
    task automatic rand_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        bit ok;
        logic [10:0] idx;
        off = addr - BASE;
        ok  = (off < 32'h0000_2000) && ((addr % 4) == 0);
        idx = 11'(off / 4);
        access(we, addr, wdata, ok, idx, 1'b0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        m_fault = 0; m_faddr = '0; m_fcnt = 0;
        check_fault_regs();
    endtask

    initial begin
        logic [31:0] taddr [2];
        int last, got, cyc, cur;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fault_clr = 1'b0;
        m_fault = 0; m_faddr = '0; m_fcnt = 0;
        #1;
        check("reset cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check("reset dm_ena", {31'b0, dm_ena}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check_fault_regs();

        // Store then load at base+4.
        access(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1'b1, 11'd1, 1'b0);
        access(1'b0, 32'h1001_0004, 32'h0, 1'b1, 11'd1, 1'b0);
        check("load DEADBEEF", ref_mem[1], 32'hDEAD_BEEF);

        // Out-of-range load, then clear.
        access(1'b0, 32'h1001_2000, 32'h0, 1'b0, 11'd0, 1'b0);
        check("first fault_addr", fault_addr, 32'h1001_2000);
        pulse_clear();

        // Misaligned store, wrapped store: first address sticks.
        access(1'b1, 32'h1001_0006, 32'h5555_AAAA, 1'b0, 11'd0, 1'b0);
        access(1'b1, 32'h1000_FFFC, 32'h5555_AAAA, 1'b0, 11'd0, 1'b0);
        check("two faults cnt", {24'b0, fault_cnt}, 32'd2);
        check("sticky fault_addr", fault_addr, 32'h1001_0006);

        for (int i = 0; i < 300; i++)
            rand_access($urandom_range(0, 1) != 0, $urandom | 32'h8000_0000, $urandom);
        check("fault_cnt saturated", {24'b0, fault_cnt}, 32'd255);

        // Clear coinciding with a fault exit: the new fault wins.
        access(1'b0, 32'h2000_0000, 32'h0, 1'b0, 11'd0, 1'b1);
        check("clr+fault addr", fault_addr, 32'h2000_0000);

        tbl[0]  = '{1'b1, 32'h1001_0000, 32'h1234_5678, 1'b1, 11'd0};
        tbl[1]  = '{1'b1, 32'h1001_1FFC, 32'hA5A5_5A5A, 1'b1, 11'd2047};
        tbl[2]  = '{1'b1, 32'h1001_0FF0, 32'h0F0F_F0F0, 1'b1, 11'd1020};
        tbl[3]  = '{1'b1, 32'h1001_2000, 32'hFFFF_FFFF, 1'b0, 11'd0};
        tbl[4]  = '{1'b1, 32'h1000_FFFC, 32'hFFFF_FFFF, 1'b0, 11'd0};
        tbl[5]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 11'd0};
        tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 11'd0};
        tbl[7]  = '{1'b1, 32'h1001_0002, 32'h7777_7777, 1'b0, 11'd0};
        tbl[8]  = '{1'b0, 32'h1001_0000, 32'h0,         1'b1, 11'd0};
        tbl[9]  = '{1'b0, 32'h1001_1FFC, 32'h0,         1'b1, 11'd2047};
        tbl[10] = '{1'b0, 32'h1001_0FF0, 32'h0,         1'b1, 11'd1020};
        tbl[11] = '{1'b0, 32'h1001_0001, 32'h0,         1'b0, 11'd0};
        for (int i = 0; i < 12; i++)
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ok, tbl[i].idx, 1'b0);

        // Randomized traffic over a pre-written window.
        for (int i = 0; i < 16; i++)
            rand_access(1'b1, BASE + 32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 3);
            if (sel <= 1)      a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 2) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else               a = $urandom | 32'h8000_0000;
            rand_access($urandom_range(0, 1) != 0, a, $urandom);
        end

        // Back-to-back loads with cpu_req held high.
        taddr[0] = BASE + 32'h0C;
        taddr[1] = BASE + 32'h24;
        last = -1; got = 0; cyc = 0; cur = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = taddr[0];
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready) begin
                if (last < 0) check("first ready cycle", cyc, 2);
                else          check("ready spacing", cyc - last, 3);
                check("stream rdata", cpu_rdata, ref_mem[(taddr[cur] - BASE) / 4]);
                last = cyc;
                got++;
                cur = 1 - cur;
                if (got < 6) cpu_addr = taddr[cur];
                else         cpu_req = 1'b0;
            end
        end
        check("stream count", got, 6);
        cpu_req = 1'b0;
        @(negedge clk);

        // Reset asserted in the middle of a store to the last word.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_1FFC; cpu_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        check("pre-reset dm_w", {31'b0, dm_w}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst dm_w", {31'b0, dm_w}, 32'h0);
        check("rst dm_ena", {31'b0, dm_ena}, 32'h0);
        check("rst dm_r", {31'b0, dm_r}, 32'h0);
        check("rst dm_addr", {21'b0, dm_addr}, 32'h0);
        check("rst dm_wdata", dm_wdata, 32'h0);
        check("rst cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check("rst cpu_rdata", cpu_rdata, 32'h0);
        m_fault = 0; m_faddr = '0; m_fcnt = 0;
        check_fault_regs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("no write after reset", mem[2047], ref_mem[2047]);
        rand_access(1'b0, 32'h1001_1FFC, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side bus bridge between the CPU31 core's data port and the DMEM word array in the single-cycle test computer. It converts the CPU's 32-bit byte address into an 11-bit word index relative to the data segment base (0x1001_0000). It rejects out-of-range and misaligned accesses, and sequences each access through a small request/ready state machine. Rejected accesses are recorded in sticky fault status registers instead of reaching DMEM. This replaces the bare subtract-and-divide address path and gives the test bench a visible data-overflow indicator.

## Interface
Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of DMEM word 0
- DEPTH_LOG2, 11, log2 of DMEM depth in words; dm_addr width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  access request, sampled in IDLE only
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- dm_ena  out  1  DMEM enable
- dm_w  out  1  DMEM write strobe
- dm_r  out  1  DMEM read strobe
- dm_addr  out  DEPTH_LOG2  DMEM word index
- dm_wdata  out  32  DMEM write data
- dm_rdata  in  32  DMEM read data, combinational from dm_addr
- fault  out  1  sticky access-fault flag
- fault_addr  out  32  cpu_addr of the first fault since the last clear
- fault_cnt  out  8  saturating fault count
- fault_clr  in  1  synchronous clear of fault, fault_addr and fault_cnt

## Operation
- States: IDLE, ACCESS, RESP, FAULT.
- IDLE, cpu_req=1:
  - Latch cpu_addr, cpu_we and cpu_wdata into internal registers.
  - Compute offset = cpu_addr - BASE_ADDR, modulo 2^32.
  - in_range = (offset[31:DEPTH_LOG2+2] == 0). Addresses below the base wrap to large values and are out of range.
  - aligned = (cpu_addr[1:0] == 0).
  - If in_range and aligned, go to ACCESS. Otherwise go to FAULT.
- ACCESS:
  - dm_ena=1.
  - dm_addr = latched offset[DEPTH_LOG2+1:2].
  - Store: dm_w=1, dm_wdata = latched wdata, dm_r=0.
  - Load: dm_r=1, dm_w=0, and cpu_rdata is loaded from dm_rdata at the clock edge that ends ACCESS.
  - Next state: RESP.
- RESP: cpu_ready=1. cpu_rdata holds the load data; it is 0 for a store. Next state: IDLE.
- FAULT:
  - cpu_ready=1, cpu_rdata=0.
  - No DMEM strobe is asserted in any cycle of the faulted access.
  - On the exit edge, fault is set to 1.
  - fault_cnt increments by 1 and saturates at 255.
  - fault_addr takes the latched address only if fault was 0 before this edge.
  - Next state: IDLE.
- fault_clr=1 at a clock edge sets fault=0, fault_addr=0 and fault_cnt=0.
  - If it coincides with a FAULT exit edge, the new fault wins: fault=1, fault_cnt=1, fault_addr = the new address.
- cpu_req is ignored in ACCESS, RESP and FAULT. Inputs may change freely after the IDLE sample, because the access uses the latched copies.
- dm_ena, dm_w and dm_r are 0 in every state other than ACCESS. dm_addr and dm_wdata hold their last value outside ACCESS.

## Timing
- Reset (rst=0): takes effect immediately, without waiting for a clock edge.
  - State returns to IDLE.
  - All outputs and internal registers go to 0.
  - Any DMEM strobe is removed in the same cycle, so no partial write completes after reset is asserted.
- Valid access: request sampled at edge N, ACCESS during cycle N+1, cpu_ready=1 during cycle N+2.
- Faulted access: request sampled at edge N, cpu_ready=1 during cycle N+1. fault is visible from cycle N+2.
- Throughput:
  - Valid accesses: one per 3 cycles, with cpu_req held high.
  - Faulted accesses: one per 2 cycles.
- The DMEM write is committed at the rising edge that ends ACCESS.
- Boundaries for DEPTH_LOG2=11:
  - 0x1001_1FFC is the last valid word; it maps to dm_addr 2047.
  - 0x1001_2000 is out of range.
  - 0x1000_FFFC is out of range because of the wrap.

## Test plan
- Store then load at 0x1001_0004, data 0xDEAD_BEEF:
  - dm_w=1 for exactly one cycle, with dm_addr=1.
  - The load returns 0xDEAD_BEEF with cpu_ready at N+2.
  - fault stays 0.
- Load at 0x1001_2000: cpu_ready at N+1 with cpu_rdata=0, no dm_r or dm_w pulse, fault=1, fault_addr=0x1001_2000, fault_cnt=1.
- Misaligned store at 0x1001_0006 followed by a store at 0x1000_FFFC:
  - No DMEM write occurs.
  - fault_cnt=2 and fault_addr stays 0x1001_0006.
  - Then 300 further faults: fault_cnt saturates at 255.
- fault_clr pulsed on the same edge as a FAULT exit for 0x2000_0000: fault=1, fault_cnt=1, fault_addr=0x2000_0000.
- rst driven low mid-ACCESS of a store to 0x1001_1FFC: dm_w drops to 0 immediately, there is no write, all outputs are 0, and the state is IDLE after release.
- cpu_req held high with valid loads at alternating addresses: cpu_ready pulses every 3 cycles, and each cpu_rdata matches a previously stored pattern.
